// File: rtl/cpu_boot_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_boot_ctrl_pkg
//   Shared definitions for the cpu boot/host sequencer:
//     - boot_state_e : 3-bit sequencer state encoding (also exported on the
//                      debug port so checkers can bind to it)
//     - BYTE_SHIFT   : word index -> byte address shift
//     - LEN_W        : width of the imem/dmem length inputs and word counter
//     - byte_addr()  : word index to 32-bit byte address
// ---------------------------------------------------------------------------
package cpu_boot_ctrl_pkg;

   localparam int BYTE_SHIFT = 2;
   localparam int LEN_W      = 16;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD_I   = 3'd1,
      ST_LOAD_D   = 3'd2,
      ST_RUN      = 3'd3,
      ST_DUMP_RD  = 3'd4,
      ST_DUMP_CAP = 3'd5,
      ST_DUMP_OUT = 3'd6,
      ST_DONE     = 3'd7
   } boot_state_e;

   function automatic logic [31:0] byte_addr(input logic [LEN_W-1:0] idx);
      byte_addr = {{(32-LEN_W-BYTE_SHIFT){1'b0}}, idx, {BYTE_SHIFT{1'b0}}};
   endfunction

endpackage

// File: rtl/cpu_boot_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_boot_ctrl
//   Host-side sequencer for the cpu top. A session loads imem_len words into
//   instruction memory, then dmem_len words into data memory, runs the core
//   for up to run_limit cycles (halt_req stops early), then streams dmem_len
//   words of data memory back out.
//
// Ports
//   clk, srst            clock, synchronous active-high reset
//   start                session start pulse (accepted in IDLE/DONE only)
//   imem_len, dmem_len   load lengths (dmem_len is also the dump length)
//   run_limit            run-cycle budget
//   halt_req             early end of the run phase
//   s_valid/s_ready/s_data   input word stream
//   m_valid/m_ready/m_data   dump word stream
//   cpu_enable           core enable
//   addr_ext, wen_ext, ren_ext, wdata_ext              imem external port
//   addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
//   rdata_ext_2          dmem external port (read data 1 cycle after ren)
//   busy, done, err, cycles  status
//   dbg_state            current sequencer state
//
// Handshake: both streams use valid/ready. A word transfers on a rising edge
// where valid && ready. A producer holding valid keeps its data stable until
// the transfer; valid never depends on ready.
// ---------------------------------------------------------------------------
module cpu_boot_ctrl
   import cpu_boot_ctrl_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int IMEM_WORDS = 512,
   parameter int DMEM_WORDS = 1024,
   parameter int CNT_W      = 32
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              start,
   input  logic [LEN_W-1:0]  imem_len,
   input  logic [LEN_W-1:0]  dmem_len,
   input  logic [CNT_W-1:0]  run_limit,
   input  logic              halt_req,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              cpu_enable,
   output logic [31:0]       addr_ext,
   output logic              wen_ext,
   output logic              ren_ext,
   output logic [31:0]       wdata_ext,
   output logic [31:0]       addr_ext_2,
   output logic              wen_ext_2,
   output logic              ren_ext_2,
   output logic [31:0]       wdata_ext_2,
   input  logic [31:0]       rdata_ext_2,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  cycles,
   output boot_state_e       dbg_state
);

   localparam logic [LEN_W-1:0] IMEM_MAX = LEN_W'(IMEM_WORDS);
   localparam logic [LEN_W-1:0] DMEM_MAX = LEN_W'(DMEM_WORDS);

   boot_state_e       state_q, state_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0]  imem_len_q, imem_len_d;
   logic [LEN_W-1:0]  dmem_len_q, dmem_len_d;
   logic [CNT_W-1:0]  run_limit_q, run_limit_d;
   logic [CNT_W-1:0]  cycles_q, cycles_d;
   logic [DATA_W-1:0] m_data_q, m_data_d;
   logic              m_valid_q, m_valid_d;
   logic              err_q, err_d;

   logic i_last, d_last, run_last, live;

   assign i_last   = (cnt_q == imem_len_q - LEN_W'(1));
   assign d_last   = (cnt_q == dmem_len_q - LEN_W'(1));
   assign run_last = (cycles_q == run_limit_q - CNT_W'(1));
   // Strobes are suppressed while srst is high so an abort takes effect at once.
   assign live     = !srst;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      imem_len_d  = imem_len_q;
      dmem_len_d  = dmem_len_q;
      run_limit_d = run_limit_q;
      cycles_d    = cycles_q;
      m_data_d    = m_data_q;
      m_valid_d   = m_valid_q;
      err_d       = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               if (imem_len > IMEM_MAX || dmem_len > DMEM_MAX) begin
                  err_d = 1'b1;
               end else begin
                  imem_len_d  = imem_len;
                  dmem_len_d  = dmem_len;
                  run_limit_d = run_limit;
                  cycles_d    = '0;
                  cnt_d       = '0;
                  // Zero-length phases are skipped entirely.
                  if (imem_len != '0)       state_d = ST_LOAD_I;
                  else if (dmem_len != '0)  state_d = ST_LOAD_D;
                  else if (run_limit != '0) state_d = ST_RUN;
                  else                      state_d = ST_DONE;
               end
            end
         end
         ST_LOAD_I: begin
            if (s_valid) begin
               if (i_last) begin
                  cnt_d = '0;
                  if (dmem_len_q != '0)       state_d = ST_LOAD_D;
                  else if (run_limit_q != '0) state_d = ST_RUN;
                  else                        state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + LEN_W'(1);
               end
            end
         end
         ST_LOAD_D: begin
            if (s_valid) begin
               if (d_last) begin
                  cnt_d   = '0;
                  state_d = (run_limit_q != '0) ? ST_RUN : ST_DUMP_RD;
               end else begin
                  cnt_d = cnt_q + LEN_W'(1);
               end
            end
         end
         ST_RUN: begin
            // The cycle in which we leave (limit or halt) is still counted.
            cycles_d = cycles_q + CNT_W'(1);
            if (run_last || halt_req) begin
               state_d = (dmem_len_q != '0) ? ST_DUMP_RD : ST_DONE;
            end
         end
         ST_DUMP_RD: begin
            state_d = ST_DUMP_CAP;
         end
         ST_DUMP_CAP: begin
            m_data_d  = DATA_W'(rdata_ext_2);
            m_valid_d = 1'b1;
            state_d   = ST_DUMP_OUT;
         end
         ST_DUMP_OUT: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               if (d_last) begin
                  cnt_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  cnt_d   = cnt_q + LEN_W'(1);
                  state_d = ST_DUMP_RD;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         imem_len_q  <= '0;
         dmem_len_q  <= '0;
         run_limit_q <= '0;
         cycles_q    <= '0;
         m_data_q    <= '0;
         m_valid_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         imem_len_q  <= imem_len_d;
         dmem_len_q  <= dmem_len_d;
         run_limit_q <= run_limit_d;
         cycles_q    <= cycles_d;
         m_data_q    <= m_data_d;
         m_valid_q   <= m_valid_d;
         err_q       <= err_d;
      end
   end

   // Each strobe is decoded from a distinct state, so they are mutually
   // exclusive and never overlap cpu_enable.
   assign s_ready     = live && (state_q == ST_LOAD_I || state_q == ST_LOAD_D);
   assign wen_ext     = live && (state_q == ST_LOAD_I) && s_valid;
   assign ren_ext     = 1'b0;
   assign addr_ext    = (state_q == ST_LOAD_I) ? byte_addr(cnt_q) : 32'd0;
   assign wdata_ext   = (state_q == ST_LOAD_I) ? 32'(s_data) : 32'd0;
   assign wen_ext_2   = live && (state_q == ST_LOAD_D) && s_valid;
   assign ren_ext_2   = live && (state_q == ST_DUMP_RD);
   assign addr_ext_2  = (state_q == ST_LOAD_D || state_q == ST_DUMP_RD) ? byte_addr(cnt_q) : 32'd0;
   assign wdata_ext_2 = (state_q == ST_LOAD_D) ? 32'(s_data) : 32'd0;
   assign cpu_enable  = live && (state_q == ST_RUN);
   assign m_valid     = m_valid_q;
   assign m_data      = m_data_q;
   assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done        = (state_q == ST_DONE);
   assign err         = err_q;
   assign cycles      = cycles_q;
   assign dbg_state   = state_q;

endmodule
